// File: rtl/ladybird_csr_arbiter.sv
// ladybird_csr_arbiter: shares the CSR file port between core and debug, sequencing accept -> write strobe -> response.
// Define LADYBIRD_CSR_ARB_DEBUG_EN to enable the debug requester and its starvation guard.
module ladybird_csr_arbiter #(
    parameter int XLEN         = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic            core_req_valid,
    output logic            core_req_ready,
    input  logic [2:0]      core_req_op,
    input  logic [11:0]     core_req_addr,
    input  logic [XLEN-1:0] core_req_data,
    output logic            core_resp_valid,
    input  logic            core_resp_ready,
    output logic [XLEN-1:0] core_resp_data,
    input  logic            dbg_req_valid,
    output logic            dbg_req_ready,
    input  logic [2:0]      dbg_req_op,
    input  logic [11:0]     dbg_req_addr,
    input  logic [XLEN-1:0] dbg_req_data,
    output logic            dbg_resp_valid,
    input  logic            dbg_resp_ready,
    output logic [XLEN-1:0] dbg_resp_data,
    input  logic            hold,
    output logic            csr_valid,
    output logic [2:0]      csr_op,
    output logic [11:0]     csr_addr,
    output logic [XLEN-1:0] csr_data,
    input  logic [XLEN-1:0] csr_rdata
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    state_t state, state_nxt;
    logic owner_dbg;
    logic [2:0] op_q;
    logic [11:0] addr_q;
    logic [XLEN-1:0] data_q, rdata_q;
    logic idle_open, dbg_v, dbg_rr, guard, core_acc, dbg_acc, resp_hs;

    // Readies are forced low while reset is asserted, not just after the state register clears.
    assign idle_open = nrst && (state == IDLE) && !hold;
    assign core_req_ready = idle_open && core_req_valid && !guard;
    assign core_acc = core_req_ready;

`ifdef LADYBIRD_CSR_ARB_DEBUG_EN
    logic [SW-1:0] starve_cnt;
    assign dbg_v = dbg_req_valid;
    assign dbg_rr = dbg_resp_ready;
    assign guard = starve_cnt == LIMIT;
    always_ff @(posedge clk or negedge nrst)
        if (!nrst)
            starve_cnt <= '0;
        else if (dbg_acc || (idle_open && !dbg_req_valid))
            starve_cnt <= '0;
        else if (core_acc && dbg_req_valid)
            starve_cnt <= starve_cnt + 1'b1;
    assign dbg_req_ready = idle_open && dbg_v && (!core_req_valid || guard);
    assign dbg_resp_valid = (state == RESP) && owner_dbg;
    assign dbg_resp_data = dbg_resp_valid ? rdata_q : '0;
`else
    logic dbg_unused;
    assign dbg_unused = ^{dbg_req_valid, dbg_resp_ready, LIMIT};
    assign dbg_v = 1'b0;
    assign dbg_rr = 1'b0;
    assign guard = 1'b0;
    assign dbg_req_ready = 1'b0;
    assign dbg_resp_valid = 1'b0;
    assign dbg_resp_data = '0;
`endif

    assign dbg_acc = dbg_req_ready && dbg_v;
    assign resp_hs = owner_dbg ? dbg_rr : core_resp_ready;

    always_ff @(posedge clk or negedge nrst)
        if (!nrst)
            state <= IDLE;
        else
            state <= state_nxt;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = (core_acc || dbg_acc) ? ACCESS : IDLE;
            ACCESS:  state_nxt = RESP;
            RESP:    state_nxt = resp_hs ? IDLE : RESP;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst)
        if (!nrst) begin
            owner_dbg <= 1'b0;
            op_q      <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            rdata_q   <= '0;
        end else begin
            if (core_acc) begin
                owner_dbg <= 1'b0;
                op_q      <= core_req_op;
                addr_q    <= core_req_addr;
                data_q    <= core_req_data;
            end else if (dbg_acc) begin
                owner_dbg <= 1'b1;
                op_q      <= dbg_req_op;
                addr_q    <= dbg_req_addr;
                data_q    <= dbg_req_data;
            end
            if (state == ACCESS)
                rdata_q <= csr_rdata;
        end

    assign csr_valid = state == ACCESS;
    assign csr_op = op_q;
    assign csr_addr = addr_q;
    assign csr_data = data_q;
    assign core_resp_valid = (state == RESP) && !owner_dbg;
    assign core_resp_data = core_resp_valid ? rdata_q : '0;
endmodule

// File: tb/tb_ladybird_csr_arbiter.sv
// tb_ladybird_csr_arbiter: table-driven and directed checks of the CSR arbiter, in either debug build.
module tb_ladybird_csr_arbiter;
    localparam int XLEN = 32;
    logic clk = 1'b0, nrst = 1'b0;
    logic core_req_valid, core_req_ready, core_resp_valid, core_resp_ready;
    logic [2:0] core_req_op, dbg_req_op, csr_op;
    logic [11:0] core_req_addr, dbg_req_addr, csr_addr;
    logic [XLEN-1:0] core_req_data, core_resp_data, dbg_req_data, dbg_resp_data, csr_data, csr_rdata;
    logic dbg_req_valid, dbg_req_ready, dbg_resp_valid, dbg_resp_ready, hold, csr_valid;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    ladybird_csr_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(4)) dut (
        .clk(clk), .nrst(nrst),
        .core_req_valid(core_req_valid), .core_req_ready(core_req_ready), .core_req_op(core_req_op),
        .core_req_addr(core_req_addr), .core_req_data(core_req_data), .core_resp_valid(core_resp_valid),
        .core_resp_ready(core_resp_ready), .core_resp_data(core_resp_data),
        .dbg_req_valid(dbg_req_valid), .dbg_req_ready(dbg_req_ready), .dbg_req_op(dbg_req_op),
        .dbg_req_addr(dbg_req_addr), .dbg_req_data(dbg_req_data), .dbg_resp_valid(dbg_resp_valid),
        .dbg_resp_ready(dbg_resp_ready), .dbg_resp_data(dbg_resp_data),
        .hold(hold), .csr_valid(csr_valid), .csr_op(csr_op), .csr_addr(csr_addr), .csr_data(csr_data),
        .csr_rdata(csr_rdata)
    );

    typedef struct {
        logic cv, dv, hold, crr;
        logic [31:0] rd;
        logic e_cr, e_dr, e_csrv, e_crv;
        logic [31:0] e_crd;
    } vec_t;
    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void add(input logic cv, dv, hd, crr, input logic [31:0] rd,
                                input logic e_cr, e_dr, e_csrv, e_crv, input logic [31:0] e_crd);
        vec_t v;
        v.cv = cv; v.dv = dv; v.hold = hd; v.crr = crr; v.rd = rd;
        v.e_cr = e_cr; v.e_dr = e_dr; v.e_csrv = e_csrv; v.e_crv = e_crv; v.e_crd = e_crd;
        vecs.push_back(v);
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        core_req_valid = 1'b1; dbg_req_valid = 1'b1; core_resp_ready = 1'b1; dbg_resp_ready = 1'b1;
        core_req_op = 3'b010; core_req_addr = 12'h300; core_req_data = 32'h8;
        dbg_req_op = 3'b001; dbg_req_addr = 12'h7b0; dbg_req_data = 32'hdead;
        hold = 1'b0; csr_rdata = '0;
        #2;
        chk("rst_core_ready", core_req_ready, 0);
        chk("rst_dbg_ready", dbg_req_ready, 0);
        chk("rst_csr_valid", csr_valid, 0);
        chk("rst_csr_addr", csr_addr, 0);
        chk("rst_core_resp_valid", core_resp_valid, 0);
        chk("rst_core_resp_data", core_resp_data, 0);
        #10;
        nrst = 1'b1; core_req_valid = 1'b0; dbg_req_valid = 1'b0;
        next_cycle();

        // single CSRRS
        add(1,0,0,1,32'h0,    1,0,0,0,0);
        add(0,0,0,1,32'h1800, 0,0,1,0,0);
        add(0,0,0,1,32'h0,    0,0,0,1,32'h1800);
        add(0,0,0,1,32'h0,    0,0,0,0,0);
        // hold blocks the grant; hold during ACCESS/RESP does not abort
        for (int i = 0; i < 5; i++) add(1,0,1,1,32'h0, 0,0,0,0,0);
        add(1,0,0,1,32'h0,    1,0,0,0,0);
        add(0,0,1,1,32'habcd, 0,0,1,0,0);
        add(0,0,1,1,32'h0,    0,0,0,1,32'habcd);
        add(1,0,1,1,32'h0,    0,0,0,0,0);
        add(0,0,0,1,32'h0,    0,0,0,0,0);
        // response stall for 10 cycles with debug waiting
        add(1,0,0,0,32'h0,    1,0,0,0,0);
        add(0,0,0,0,32'h5a5a, 0,0,1,0,0);
        for (int i = 0; i < 10; i++) add(0,1,0,0,32'hffff, 0,0,0,1,32'h5a5a);
        add(0,1,0,1,32'h0,    0,0,0,1,32'h5a5a);
        add(0,0,0,1,32'h0,    0,0,0,0,0);
        // back-to-back core cadence, debug also requesting
        add(1,1,0,1,32'h0,  1,0,0,0,0);
        add(1,1,0,1,32'h11, 0,0,1,0,0);
        add(1,1,0,1,32'h0,  0,0,0,1,32'h11);
        add(1,1,0,1,32'h0,  1,0,0,0,0);
        add(1,1,0,1,32'h22, 0,0,1,0,0);
        add(1,1,0,1,32'h0,  0,0,0,1,32'h22);
        add(0,0,0,1,32'h0,  0,0,0,0,0);

        foreach (vecs[i]) begin
            core_req_valid = vecs[i].cv; dbg_req_valid = vecs[i].dv; hold = vecs[i].hold;
            core_resp_ready = vecs[i].crr; dbg_resp_ready = 1'b0; csr_rdata = vecs[i].rd;
            @(negedge clk);
            chk($sformatf("v%0d_core_ready", i), core_req_ready, vecs[i].e_cr);
            chk($sformatf("v%0d_dbg_ready", i), dbg_req_ready, vecs[i].e_dr);
            chk($sformatf("v%0d_csr_valid", i), csr_valid, vecs[i].e_csrv);
            chk($sformatf("v%0d_core_resp_valid", i), core_resp_valid, vecs[i].e_crv);
            chk($sformatf("v%0d_dbg_resp_valid", i), dbg_resp_valid, 0);
            if (vecs[i].e_crv) chk($sformatf("v%0d_core_resp_data", i), core_resp_data, vecs[i].e_crd);
            if (vecs[i].e_csrv) begin
                chk($sformatf("v%0d_csr_op", i), csr_op, 3'b010);
                chk($sformatf("v%0d_csr_addr", i), csr_addr, 12'h300);
                chk($sformatf("v%0d_csr_data", i), csr_data, 32'h8);
            end
            next_cycle();
        end

        // asynchronous reset in the middle of ACCESS
        core_req_valid = 1'b1; core_req_addr = 12'h341; core_resp_ready = 1'b1;
        next_cycle();
        @(negedge clk);
        chk("ar_csr_valid_before", csr_valid, 1);
        chk("ar_csr_addr_before", csr_addr, 12'h341);
        nrst = 1'b0;
        #1;
        chk("ar_csr_valid", csr_valid, 0);
        chk("ar_csr_addr", csr_addr, 0);
        chk("ar_csr_op", csr_op, 0);
        chk("ar_core_ready", core_req_ready, 0);
        chk("ar_core_resp_valid", core_resp_valid, 0);
        core_req_valid = 1'b0;
        #2;
        nrst = 1'b1;
        next_cycle();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("ar_no_resp%0d", i), core_resp_valid, 0);
            next_cycle();
        end
        core_req_valid = 1'b1;
        @(negedge clk);
        chk("ar2_accept", core_req_ready, 1);
        next_cycle();
        core_req_valid = 1'b0; csr_rdata = 32'h77;
        @(negedge clk);
        chk("ar2_csr_addr", csr_addr, 12'h341);
        next_cycle();
        csr_rdata = 32'h0;
        @(negedge clk);
        chk("ar2_resp_valid", core_resp_valid, 1);
        chk("ar2_resp_data", core_resp_data, 32'h77);
        next_cycle();
        core_req_addr = 12'h300;

`ifdef LADYBIRD_CSR_ARB_DEBUG_EN
        // core response stall, then debug accepted right after the handshake
        core_req_valid = 1'b1; core_resp_ready = 1'b0;
        next_cycle();
        core_req_valid = 1'b0; dbg_req_valid = 1'b1; csr_rdata = 32'h99;
        next_cycle();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("ds_core_resp%0d", i), core_resp_data, 32'h99);
            chk($sformatf("ds_dbg_ready%0d", i), dbg_req_ready, 0);
            next_cycle();
        end
        core_resp_ready = 1'b1;
        next_cycle();
        @(negedge clk);
        chk("ds_dbg_accept", dbg_req_ready, 1);
        next_cycle();
        dbg_req_valid = 1'b0; dbg_resp_ready = 1'b0; csr_rdata = 32'h4242;
        @(negedge clk);
        chk("ds_dbg_csr_addr", csr_addr, 12'h7b0);
        chk("ds_dbg_csr_data", csr_data, 32'hdead);
        next_cycle();
        @(negedge clk);
        chk("ds_dbg_resp_valid", dbg_resp_valid, 1);
        chk("ds_dbg_resp_data", dbg_resp_data, 32'h4242);
        chk("ds_core_resp_quiet", core_resp_valid, 0);
        next_cycle();
        dbg_resp_ready = 1'b1;
        next_cycle();
        @(negedge clk);
        chk("ds_idle", dbg_resp_valid, 0);
        next_cycle();
        // starvation guard: C,C,C,C,D repeating
        core_req_valid = 1'b1; dbg_req_valid = 1'b1; core_resp_ready = 1'b1; dbg_resp_ready = 1'b1;
        for (int g = 0; g < 10; g++) begin
            logic exp_d;
            exp_d = (g % 5) == 4;
            @(negedge clk);
            chk($sformatf("sg%0d_core_ready", g), core_req_ready, !exp_d);
            chk($sformatf("sg%0d_dbg_ready", g), dbg_req_ready, exp_d);
            next_cycle();
            csr_rdata = 32'h100 + g;
            @(negedge clk);
            chk($sformatf("sg%0d_csr_addr", g), csr_addr, exp_d ? 12'h7b0 : 12'h300);
            next_cycle();
            csr_rdata = 32'h0;
            @(negedge clk);
            chk($sformatf("sg%0d_core_resp_valid", g), core_resp_valid, !exp_d);
            chk($sformatf("sg%0d_resp_data", g), exp_d ? dbg_resp_data : core_resp_data, 32'h100 + g);
            next_cycle();
        end
`else
        // debug requester ignored; core keeps a 3-cycle cadence
        core_req_valid = 1'b1; dbg_req_valid = 1'b1; dbg_resp_ready = 1'b1; core_resp_ready = 1'b1;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            chk($sformatf("nd%0d_core_ready", c), core_req_ready, (c % 3) == 0);
            chk($sformatf("nd%0d_dbg_ready", c), dbg_req_ready, 0);
            chk($sformatf("nd%0d_dbg_resp", c), {dbg_resp_valid, dbg_resp_data}, 0);
            chk($sformatf("nd%0d_core_resp_valid", c), core_resp_valid, (c % 3) == 2);
            next_cycle();
        end
`endif
        core_req_valid = 1'b0; dbg_req_valid = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
